sram_sp_param: RTL
==================

SRAM_SP_PARAM -- requirements
Module: sram_sp_param

Interface
REQ-001 Parameter DW, default 64: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 6: address width; depth DEPTH = 2**AW words.
REQ-003 clk_i  input  1  sole clock; all state on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 clr_i  input  1  request to zero the whole array.
REQ-006 wr_en_i  input  1  write strobe.
REQ-007 wr_mask_i  input  DW/8  byte-lane write enables; bit k gates wdata_i[8k+7:8k].
REQ-008 rd_en_i  input  1  read strobe.
REQ-009 addr_i  input  AW  word address, shared by read and write.
REQ-010 wdata_i  input  DW  write data.
REQ-011 rdata_o  output  DW  read data, registered.
REQ-012 rvalid_o  output  1  one-cycle pulse marking rdata_o valid.
REQ-013 busy_o  output  1  high while the array is being cleared; accesses are dropped.

Function
REQ-014 Controller states SHALL be IDLE and CLEAR.
- IDLE to CLEAR on reset release or on clr_i=1.
- CLEAR to IDLE after clearing address DEPTH-1.
REQ-015 In CLEAR, a clear counter SHALL start at 0 and zero one word per cycle, address = counter.
- Sweep lasts DEPTH cycles; busy_o=1 on every one of them.
REQ-016 clr_i SHALL be ignored while in CLEAR; the sweep does not restart.
REQ-017 wr_en_i and rd_en_i SHALL be ignored while busy_o=1: no array change, no rvalid_o.
REQ-018 In IDLE, a write SHALL update only the lanes with wr_mask_i[k]=1; other lanes keep their value.
- wr_mask_i=0 with wr_en_i=1 is a no-op.
REQ-019 In IDLE, rd_en_i=1 in cycle N SHALL present bram[addr_i] on rdata_o with rvalid_o=1 in cycle N+1 (base latency 1).
REQ-020 rvalid_o SHALL be low in every cycle not following an accepted read.
- rdata_o holds its last value and is never high-impedance.
REQ-021 Simultaneous rd_en_i and wr_en_i in IDLE SHALL perform both accesses.
- Same address: the read returns the pre-write contents (read-first).
REQ-022 clr_i with rd_en_i/wr_en_i in the same IDLE cycle SHALL complete that access; CLEAR starts the next cycle.
REQ-023 Back-to-back reads SHALL be accepted every cycle with no bubbles.

Reset
REQ-024 When rst_i=1 at a clock edge:
- rdata_o=0, rvalid_o=0, busy_o=1;
- state=CLEAR, clear counter=0;
- any output-pipeline contents discarded.
REQ-025 Array contents SHALL NOT be reset in one cycle; zeroing happens only through the CLEAR sweep.
REQ-026 rst_i asserted mid-sweep SHALL restart the sweep at address 0.

Configuration
REQ-027 Macro SRAM_OUTREG_EN:
- Defined: one extra output register stage; read latency 2, rvalid_o delayed to match, throughput unchanged.
- Undefined: latency 1 as in REQ-019.

Structure
REQ-028 Package sram_pkg SHALL hold:
- the controller state enum (IDLE, CLEAR);
- lane width constant LANE_W=8;
- default DW/AW constants.
REQ-029 The clear controller (state, counter, busy_o) SHALL be sub-module sram_clr_ctrl; the array and read path stay in sram_sp_param.

Verification
REQ-030 Reset with DW=64, AW=6: hold rst_i 1 cycle -> busy_o=1 for exactly 64 cycles, then 0; reads of addr 0..63 return 0.
REQ-031 Mask write addr 5, wdata 0x1122334455667788, mask 0x0F, over prior 0xFFFFFFFFFFFFFFFF -> read returns 0xFFFFFFFF55667788 one cycle later, rvalid_o one pulse.
REQ-032 Same cycle rd_en_i+wr_en_i to addr 9, old 0xA, new 0xB, full mask -> rdata_o=0xA next cycle; a following read gives 0xB.
REQ-033 clr_i in IDLE, then rd_en_i at addr 3 during busy -> no rvalid_o; after sweep, addr 3 reads 0.
REQ-034 rst_i at sweep cycle 20 -> busy_o stays high 64 more cycles; all addresses read 0.
REQ-035 With SRAM_OUTREG_EN defined: reads on 4 consecutive cycles -> 4 consecutive rvalid_o pulses starting 2 cycles after the first read, with data in order.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the single-port SRAM slice.
// Contents: clear-controller state enum, byte-lane width, default geometry.
package sram_pkg;

  localparam int unsigned LANE_W     = 8;
  localparam int unsigned DEFAULT_DW = 64;
  localparam int unsigned DEFAULT_AW = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/sram_clr_ctrl.sv
// Clear controller: sweeps the array to zero one word per cycle.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   clr_i         request a full clear (honoured only in IDLE)
//   busy_o        high for every cycle of the sweep, registered
//   clr_addr_o    word being zeroed this cycle, registered
// Reset enters CLEAR with the counter at 0, so the array is zeroed after reset.
module sram_clr_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned AW = DEFAULT_AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  output logic          busy_o,
  output logic [AW-1:0] clr_addr_o
);

  localparam int unsigned DEPTH = 1 << AW;

  clr_state_e state;

  // Controller state, sweep counter and busy flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= CLEAR;
      clr_addr_o <= '0;
      busy_o     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_i) begin
            state      <= CLEAR;
            clr_addr_o <= '0;
            busy_o     <= 1'b1;
          end
        end
        CLEAR: begin
          // clr_i is deliberately ignored here: a running sweep never restarts
          clr_addr_o <= clr_addr_o + AW'(1);
          if (clr_addr_o == AW'(DEPTH - 1)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state      <= CLEAR;
          clr_addr_o <= '0;
          busy_o     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/sram_sp_param.sv
// Single-port SRAM with byte-lane write mask, read-first behaviour and a
// background clear sweep after reset or on request.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   clr_i               zero the whole array (sweep of 2**AW cycles)
//   wr_en_i, wr_mask_i  write strobe and per-byte lane enables
//   rd_en_i             read strobe
//   addr_i, wdata_i     shared word address, write data
//   rdata_o, rvalid_o   registered read data and one-cycle valid pulse
//   busy_o              high during the clear sweep; accesses are dropped
// Config macro SRAM_OUTREG_EN: adds an output register stage (read latency 2).
module sram_sp_param
  import sram_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW,
  parameter int unsigned AW = DEFAULT_AW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic [DW/LANE_W-1:0] wr_mask_i,
  input  logic                 rd_en_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DW-1:0]        wdata_i,
  output logic [DW-1:0]        rdata_o,
  output logic                 rvalid_o,
  output logic                 busy_o
);

  localparam int unsigned NLANE = DW / LANE_W;
  localparam int unsigned DEPTH = 1 << AW;

  if ((DW % LANE_W) != 0) begin : g_dw_check
    $error("sram_sp_param: DW must be a multiple of 8");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] clr_addr;
  logic          rd_acc_c;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;

  sram_clr_ctrl #(.AW(AW)) u_clr_ctrl (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .busy_o     (busy_o),
    .clr_addr_o (clr_addr)
  );

  assign rd_acc_c = rd_en_i & ~busy_o;

  // Array write port: sweep zeroing has priority, user writes only when idle
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (busy_o) begin
        mem[clr_addr] <= '0;
      end else if (wr_en_i) begin
        for (int k = 0; k < NLANE; k++) begin
          if (wr_mask_i[k]) begin
            mem[addr_i][k*LANE_W +: LANE_W] <= wdata_i[k*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  // First read stage; nonblocking update gives read-first on same-address writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc_c;
      if (rd_acc_c) begin
        rdata_q <= mem[addr_i];
      end
    end
  end

`ifdef SRAM_OUTREG_EN
  logic [DW-1:0] rdata_q2;
  logic          rvalid_q2;

  // Optional output stage; data only advances with a valid beat so rdata_o holds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q2  <= '0;
      rvalid_q2 <= 1'b0;
    end else begin
      rvalid_q2 <= rvalid_q;
      if (rvalid_q) begin
        rdata_q2 <= rdata_q;
      end
    end
  end

  assign rdata_o  = rdata_q2;
  assign rvalid_o = rvalid_q2;
`else
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
`endif

endmodule
